// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and result bus
// for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, blank
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble converter, one bit per clock.
// Optional leading-zero blanking: LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  bin_to_bcd_seq_if.slave io
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS) - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [BIN_W-1:0]    sh_q, sh_d;
  logic [SW-1:0]       scr_q, scr_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [SW+BIN_W-1:0] cat;

  logic [SW-1:0]       bcd_q;
  logic                ovr_q;
  logic                done_q;

  // add-3 on every scratch digit that is 5 or more
  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
  end

  // next state and next shift/scratch/counter values
  always_comb begin
    state_nx = state;
    sh_d     = sh_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    cat      = {adj, sh_q} << 1;
    unique case (state)
      S_IDLE: begin
        if (io.start) begin
          sh_d     = io.bin_in;
          scr_d    = '0;
          ovf_d    = 32'(io.bin_in) > MAXV;
          cnt_d    = CW'(BIN_W);
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d = cat[SW+BIN_W-1:BIN_W];
        sh_d  = cat[BIN_W-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // conversion datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // result registers: update only when leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      ovr_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (state == S_DONE) begin
        bcd_q <= ovf_q ? {DIGITS{4'h9}} : scr_q;
        ovr_q <= ovf_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  function automatic logic [DIGITS-1:0] lz_mask(
    input logic [SW-1:0] d
  );
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z    = z & (d[4*k +: 4] == 4'd0);
      m[k] = z;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  // blank mask registered alongside bcd_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank_q <= '0;
    else if (state == S_DONE)
      blank_q <= ovf_q ? '0 : lz_mask(scr_q);
  end

  assign io.blank = blank_q;
`else
  assign io.blank = '0;
`endif

  assign io.busy     = (state != S_IDLE);
  assign io.done     = done_q;
  assign io.bcd_out  = bcd_q;
  assign io.overflow = ovr_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: random and directed conversions against an
// arithmetic decimal model; honours LEADING_ZERO_BLANK_EN.
module tb_bin_to_bcd_seq;
  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic clk;
  logic rst_n;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;
  logic [15:0] prev_bcd;
  logic        prev_ovf;
  logic [3:0]  prev_blank;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    if (v > 9999) return 16'h9999;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_blank(input int v);
    logic [3:0] b;
    b = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (v <= 9999) begin
      b[1] = (v < 10);
      b[2] = (v < 100);
      b[3] = (v < 1000);
    end
`endif
    return b;
  endfunction

  // caller is at a negedge; leaves at a negedge in IDLE
  task automatic conv(input int v, input bit hold, input bit inj);
    int j;
    int bc;
    chk("idle_before", 32'(bus.busy), 0);
    bus.start  = 1'b1;
    bus.bin_in = 14'(v);
    @(posedge clk);
    @(negedge clk);
    j  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && j < 40) begin
      if (!hold) bus.start = 1'b0;
      bus.bin_in = 14'($urandom);
      if (inj && j == 4) begin
        bus.start  = 1'b1;
        bus.bin_in = 14'd5555;
      end
      if (bus.busy) bc++;
      if (j == 7) begin
        chk("hold_bcd", 32'(bus.bcd_out), 32'(prev_bcd));
        chk("hold_ovf", 32'(bus.overflow), 32'(prev_ovf));
      end
      @(negedge clk);
      j++;
    end
    chk("latency", j, 15);
    chk("busy_cycles", bc, 15);
    chk("busy_at_done", 32'(bus.busy), 0);
    chk("bcd_out", 32'(bus.bcd_out), 32'(m_bcd(v)));
    chk("overflow", 32'(bus.overflow), (v > 9999) ? 1 : 0);
    chk("blank", 32'(bus.blank), 32'(m_blank(v)));
    prev_bcd   = m_bcd(v);
    prev_ovf   = (v > 9999);
    prev_blank = m_blank(v);
    bus.bin_in = 14'($urandom);
    if (!hold) begin
      bus.start = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 0);
    end
  endtask

  task automatic reset_mid(input int v);
    int seen;
    bus.start  = 1'b1;
    bus.bin_in = 14'(v);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_bcd", 32'(bus.bcd_out), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_blank", 32'(bus.blank), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_bcd   = '0;
    prev_ovf   = 1'b0;
    prev_blank = '0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("rst_no_done", seen, 0);
  endtask

  initial begin
    int v;
    errs       = 0;
    checks     = 0;
    prev_bcd   = '0;
    prev_ovf   = 1'b0;
    prev_blank = '0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_bcd", 32'(bus.bcd_out), 0);
    chk("reset_ovf", 32'(bus.overflow), 0);
    chk("reset_blank", 32'(bus.blank), 0);
    rst_n = 1'b1;
    @(negedge clk);

    conv(0, 0, 0);
    conv(1234, 0, 0);
    conv(9999, 1, 0);
    conv(4321, 0, 0);
    conv(10000, 0, 0);
    conv(7, 0, 0);
    conv(42, 0, 1);
    conv(1000, 0, 0);
    conv(16383, 0, 0);
    reset_mid(3333);
    conv(5678, 0, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        v = int'($urandom_range(0, 16383));
      else
        v = int'($urandom_range(0, 9999));
      conv(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
